// File: rtl/pwm_array_pkg.sv
// pwm_array_pkg: shared constants for the config-frame parser and the PWM channels.
package pwm_array_pkg;
  localparam int CH_MSB   = 31;
  localparam int CH_LSB   = 24;
  localparam int EN_BIT   = 23;
  localparam int MODE_BIT = 22;
  localparam int INV_BIT  = 21;
  localparam int W_HDR = 0;
  localparam int W_PER = 1;
  localparam int W_HLV = 2;
  localparam int W_PHS = 3;
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_W1, S_W2, S_W3, S_COMMIT, S_DISCARD} state_t;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel with shadowed config, edge/center counter and registered output.
// PWM_INVERT_EN adds a shadowed per-channel output polarity.
module pwm_chan
  import pwm_array_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic             i_en,
  input  logic             i_mode,
`ifdef PWM_INVERT_EN
  input  logic             i_inv,
`endif
  input  logic [CNT_W-1:0] i_per,
  input  logic [CNT_W-1:0] i_hlv,
  input  logic [CNT_W-1:0] i_phs,
  input  logic             i_sync,
  output logic             o_pwm
);
  logic             r_sh_en, r_sh_mode, r_pend, r_en, r_mode, r_dn, r_pwm;
  logic [CNT_W-1:0] r_sh_per, r_sh_hlv, r_sh_phs, r_per, r_hlv, r_phs, r_cnt;
  logic             w_end, w_turn, w_apply, w_reload, w_en, w_lvl, w_out, w_dn;
  logic [CNT_W-1:0] w_top, w_per, w_phs, w_load, w_step, w_cnt;
  assign w_top    = r_per - CNT_W'(1);
  assign w_turn   = r_mode == MODE_CENTER && (r_dn ? r_cnt == '0 : r_cnt >= w_top);
  assign w_end    = r_per == '0 || (r_mode == MODE_CENTER ? r_dn && r_cnt == '0 : r_cnt >= w_top);
  assign w_apply  = r_pend && (w_end || i_sync || !r_en);
  assign w_en     = w_apply ? r_sh_en : r_en;
  assign w_per    = w_apply ? r_sh_per : r_per;
  assign w_phs    = w_apply ? r_sh_phs : r_phs;
  assign w_load   = w_phs >= w_per ? '0 : w_phs;
  assign w_reload = i_sync || (w_apply && !r_en);
  // center mode dwells one extra cycle at each extreme while the direction flips
  assign w_step   = r_mode == MODE_EDGE ? (r_cnt >= w_top ? '0 : r_cnt + CNT_W'(1))
                  : w_turn ? r_cnt : r_dn ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_cnt    = !w_en ? '0 : w_reload ? w_load : w_end ? '0 : w_step;
  assign w_dn     = w_en && !w_reload && !w_end && (w_turn ? !r_dn : r_dn);
  assign w_lvl    = r_per != '0 && r_hlv != '0 &&
                    (r_hlv >= r_per || (r_mode == MODE_CENTER ? r_cnt >= r_per - r_hlv : r_cnt < r_hlv));
`ifdef PWM_INVERT_EN
  logic r_sh_inv, r_inv;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sh_inv <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      if (i_wr) r_sh_inv <= i_inv;
      if (w_apply) r_inv <= r_sh_inv;
    end
  assign w_out = w_lvl ^ r_inv;
`else
  assign w_out = w_lvl;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sh_en   <= 1'b0;
      r_sh_mode <= 1'b0;
      r_sh_per  <= '0;
      r_sh_hlv  <= '0;
      r_sh_phs  <= '0;
      r_pend    <= 1'b0;
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_per     <= '0;
      r_hlv     <= '0;
      r_phs     <= '0;
      r_cnt     <= '0;
      r_dn      <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      if (i_wr) begin
        r_sh_en   <= i_en;
        r_sh_mode <= i_mode;
        r_sh_per  <= i_per;
        r_sh_hlv  <= i_hlv;
        r_sh_phs  <= i_phs;
      end
      r_pend <= i_wr || (r_pend && !w_apply);
      if (w_apply) begin
        r_en   <= r_sh_en;
        r_mode <= r_sh_mode;
        r_per  <= r_sh_per;
        r_hlv  <= r_sh_hlv;
        r_phs  <= r_sh_phs;
      end
      r_cnt <= w_cnt;
      r_dn  <= w_dn;
      r_pwm <= w_en && r_en && w_out;
    end
  assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_array.sv
// pwm_array: multi-channel PWM configured by 4-word frames on the UDP receive stream.
// PWM_INVERT_EN enables header bit 21 as per-channel output polarity.
module pwm_array
  import pwm_array_pkg::*;
#(
  parameter int         PWM_NUM      = 4,
  parameter int         CNT_W        = 28,
  parameter logic [7:0] ID_PWM_PARAM = 8'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        rx_axis_udp_tdata,
  input  logic               rx_axis_udp_tvalid,
  input  logic               rx_axis_udp_tlast,
  input  logic [7:0]         rx_axis_udp_tuser,
  input  logic               sync_in,
  output logic               cfg_err,
  output logic [PWM_NUM-1:0] pwm
);
  state_t           r_state, w_next;
  logic             r_cfg_err, r_en, r_mode, w_err, w_commit, w_hit, w_vld, w_last;
  logic [7:0]       r_ch;
  logic [CNT_W-1:0] r_per, r_hlv, r_phs;
  assign w_vld  = rx_axis_udp_tvalid;
  assign w_last = rx_axis_udp_tlast;
  assign w_hit  = w_vld && rx_axis_udp_tuser == ID_PWM_PARAM;
  always_comb begin
    w_next   = r_state;
    w_err    = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: if (w_hit) begin
        w_next = w_last ? S_IDLE : S_W1;
        w_err  = w_last;
      end
      S_W1, S_W2: if (w_vld) begin
        w_next = w_last ? S_IDLE : r_state == S_W1 ? S_W2 : S_W3;
        w_err  = w_last;
      end
      S_W3: if (w_vld) begin
        w_next = w_last ? S_COMMIT : S_DISCARD;
        w_err  = !w_last;
      end
      S_COMMIT: begin
        w_next   = S_IDLE;
        w_commit = int'(r_ch) < PWM_NUM;
        w_err    = !(int'(r_ch) < PWM_NUM);
      end
      S_DISCARD: if (w_vld && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_IDLE;
      r_cfg_err <= 1'b0;
      r_ch      <= '0;
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_per     <= '0;
      r_hlv     <= '0;
      r_phs     <= '0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= w_err;
      if (r_state == S_IDLE && w_next == S_W1) begin
        r_ch   <= rx_axis_udp_tdata[CH_MSB:CH_LSB];
        r_en   <= rx_axis_udp_tdata[EN_BIT];
        r_mode <= rx_axis_udp_tdata[MODE_BIT];
      end
      if (w_vld && r_state == S_W1) r_per <= rx_axis_udp_tdata[CNT_W-1:0];
      if (w_vld && r_state == S_W2) r_hlv <= rx_axis_udp_tdata[CNT_W-1:0];
      if (w_vld && r_state == S_W3) r_phs <= rx_axis_udp_tdata[CNT_W-1:0];
    end
`ifdef PWM_INVERT_EN
  logic r_inv;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_inv <= 1'b0;
    else if (r_state == S_IDLE && w_next == S_W1) r_inv <= rx_axis_udp_tdata[INV_BIT];
`endif
  assign cfg_err = r_cfg_err;
  for (genvar i = 0; i < PWM_NUM; i++) begin : g_ch
    pwm_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_commit && int'(r_ch) == i),
      .i_en   (r_en),
      .i_mode (r_mode),
`ifdef PWM_INVERT_EN
      .i_inv  (r_inv),
`endif
      .i_per  (r_per),
      .i_hlv  (r_hlv),
      .i_phs  (r_phs),
      .i_sync (sync_in),
      .o_pwm  (pwm[i])
    );
  end
endmodule
